// File: rtl/f_edge_counter.sv
// Glitch filter on the registered AND-OR output f, qualified rising-edge detector and event counter
// with sticky threshold/overflow flags. Define F_EDGE_CNT_SAT_EN to make the counter saturate instead of wrap.
module f_edge_counter #(
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 3,
  parameter int THRESH   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_in,
  input  logic             en,
  input  logic             clr,
  output logic             filt_level,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] count,
  output logic             thresh_hit,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_RISING  = 2'd1,
    S_HIGH    = 2'd2,
    S_FALLING = 2'd3
  } state_t;

  localparam logic [3:0]       STAB_LAST = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_V  = CNT_W'(THRESH);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_stab_cnt;
  logic [3:0]       w_stab_next;
  logic             w_rise;
  logic             r_filt_level;
  logic             r_edge_pulse;
  logic [CNT_W-1:0] r_count;
  logic             r_thresh_hit;
  logic             r_overflow;
  logic             w_inc;
  logic [CNT_W-1:0] w_count_plus;

  // Filter next-state: a new level must persist FILT_LEN samples to be accepted.
  always_comb begin
    w_state_next = r_state;
    w_stab_next  = r_stab_cnt;
    w_rise       = 1'b0;
    case (r_state)
      S_LOW: begin
        if (f_in) begin
          if (FILT_LEN == 1) begin
            w_state_next = S_HIGH;
            w_stab_next  = 4'd0;
            w_rise       = 1'b1;
          end else begin
            w_state_next = S_RISING;
            w_stab_next  = 4'd1;
          end
        end
      end
      S_RISING: begin
        if (!f_in) begin
          w_state_next = S_LOW;
          w_stab_next  = 4'd0;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_next = S_HIGH;
          w_stab_next  = 4'd0;
          w_rise       = 1'b1;
        end else begin
          w_stab_next = r_stab_cnt + 4'd1;
        end
      end
      S_HIGH: begin
        if (!f_in) begin
          if (FILT_LEN == 1) begin
            w_state_next = S_LOW;
            w_stab_next  = 4'd0;
          end else begin
            w_state_next = S_FALLING;
            w_stab_next  = 4'd1;
          end
        end
      end
      S_FALLING: begin
        if (f_in) begin
          w_state_next = S_HIGH;
          w_stab_next  = 4'd0;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_next = S_LOW;
          w_stab_next  = 4'd0;
        end else begin
          w_stab_next = r_stab_cnt + 4'd1;
        end
      end
      default: begin
        w_state_next = S_LOW;
        w_stab_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_LOW;
      r_stab_cnt   <= 4'd0;
      r_filt_level <= 1'b0;
      r_edge_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_stab_cnt   <= w_stab_next;
      r_filt_level <= (w_state_next == S_HIGH) || (w_state_next == S_FALLING);
      r_edge_pulse <= w_rise;
    end
  end

  // Counting uses the same qualifying edge that launches edge_pulse, so both appear together.
  assign w_inc        = w_rise && en && !clr;
  assign w_count_plus = r_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count      <= '0;
      r_thresh_hit <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (clr) begin
      r_count      <= '0;
      r_thresh_hit <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (w_inc) begin
      if (r_count == CNT_MAX) begin
        r_overflow <= 1'b1;
`ifdef F_EDGE_CNT_SAT_EN
        r_count    <= CNT_MAX;
`else
        r_count    <= '0;
`endif
      end else begin
        r_count <= w_count_plus;
        if (w_count_plus == THRESH_V) begin
          r_thresh_hit <= 1'b1;
        end
      end
    end
  end

  assign filt_level = r_filt_level;
  assign edge_pulse = r_edge_pulse;
  assign count      = r_count;
  assign thresh_hit = r_thresh_hit;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_f_edge_counter.sv
// Self-checking bench for f_edge_counter: directed scenarios plus randomized f_in/en/clr,
// checked every cycle against a run-length reference model.
module tb_f_edge_counter;
  localparam int CNT_W    = 4;
  localparam int FILT_LEN = 3;
  localparam int THRESH   = 10;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef F_EDGE_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             f_in;
  logic             en;
  logic             clr;
  logic             filt_level;
  logic             edge_pulse;
  logic [CNT_W-1:0] count;
  logic             thresh_hit;
  logic             overflow;

  int n_checks   = 0;
  int n_failures = 0;
  int obs_pulses = 0;

  // Reference model: level flips once FILT_LEN consecutive samples disagree with it.
  int m_level, m_run, m_pulse, m_count, m_thresh, m_ovf;

  f_edge_counter #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .THRESH(THRESH)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_in      (f_in),
    .en        (en),
    .clr       (clr),
    .filt_level(filt_level),
    .edge_pulse(edge_pulse),
    .count     (count),
    .thresh_hit(thresh_hit),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_failures++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_run = 0; m_pulse = 0; m_count = 0; m_thresh = 0; m_ovf = 0;
  endtask

  task automatic step(input logic f, input logic e, input logic c);
    @(negedge clk);
    f_in = f; en = e; clr = c;
    @(posedge clk);
    m_pulse = 0;
    if (int'(f) != m_level) begin
      m_run++;
      if (m_run == FILT_LEN) begin
        m_level = int'(f);
        m_run   = 0;
        m_pulse = int'(f);
      end
    end else begin
      m_run = 0;
    end
    if (c) begin
      m_count = 0; m_thresh = 0; m_ovf = 0;
    end else if (m_pulse == 1 && e) begin
      if (m_count == CNT_MAX) begin
        m_ovf   = 1;
        m_count = SAT ? CNT_MAX : 0;
      end else begin
        m_count++;
        if (m_count == THRESH) m_thresh = 1;
      end
    end
    #1;
    check_val("filt_level", int'(filt_level), m_level);
    check_val("edge_pulse", int'(edge_pulse), m_pulse);
    check_val("count",      int'(count),      m_count);
    check_val("thresh_hit", int'(thresh_hit), m_thresh);
    check_val("overflow",   int'(overflow),   m_ovf);
    obs_pulses += int'(edge_pulse);
  endtask

  // Async reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_filt",   int'(filt_level), 0);
    check_val("rst_pulse",  int'(edge_pulse), 0);
    check_val("rst_count",  int'(count),      0);
    check_val("rst_thresh", int'(thresh_hit), 0);
    check_val("rst_ovf",    int'(overflow),   0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; f_in = 1'b0; clr = 1'b0; en = 1'b1;
  endtask

  task automatic clean_pulses(input int n, input logic e);
    for (int p = 0; p < n; p++) begin
      for (int h = 0; h < 4; h++) step(1'b1, e, 1'b0);
      for (int l = 0; l < 4; l++) step(1'b0, e, 1'b0);
    end
  endtask

  initial begin
    int first_idx;
    int base_count;
    rst = 1'b0; f_in = 1'b0; en = 1'b1; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Held high: pulse appears after the third high sample.
    obs_pulses = 0; first_idx = 0;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (edge_pulse && first_idx == 0) first_idx = i;
    end
    check_val("latency", first_idx, 3);
    check_val("hold_pulses", obs_pulses, 1);
    check_val("hold_count", int'(count), 1);
    $display("scenario hold_high: first_pulse_at=%0d count=%0d", first_idx, count);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // Glitches of 2 cycles never qualify.
    obs_pulses = 0;
    for (int g = 0; g < 5; g++) begin
      step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    end
    check_val("glitch_pulses", obs_pulses, 0);
    check_val("glitch_count", int'(count), 0);
    check_val("glitch_level", int'(filt_level), 0);
    $display("scenario glitches: pulses=%0d count=%0d", obs_pulses, count);

    // Ten clean pulses reach THRESH, then clr collides with the 11th edge.
    clean_pulses(10, 1'b1);
    check_val("ten_count", int'(count), 10);
    check_val("ten_thresh", int'(thresh_hit), 1);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_val("clr_edge_pulse", int'(edge_pulse), 1);
    check_val("clr_count", int'(count), 0);
    check_val("clr_thresh", int'(thresh_hit), 0);
    $display("scenario thresh_clr: count=%0d thresh_hit=%0d", count, thresh_hit);
    step(1'b1, 1'b1, 1'b0);
    for (int l = 0; l < 4; l++) step(1'b0, 1'b1, 1'b0);

    // en low: pulses still generated, count frozen.
    obs_pulses = 0; base_count = int'(count);
    clean_pulses(3, 1'b0);
    check_val("en0_pulses", obs_pulses, 3);
    check_val("en0_count", int'(count), base_count);
    $display("scenario en_low: pulses=%0d count=%0d", obs_pulses, count);

    // Overflow at CNT_MAX.
    step(1'b0, 1'b1, 1'b1);
    clean_pulses(16, 1'b1);
    check_val("ovf_flag", int'(overflow), 1);
    check_val("ovf_count", int'(count), SAT ? CNT_MAX : 0);
    check_val("ovf_thresh", int'(thresh_hit), 1);
    $display("scenario overflow: count=%0d overflow=%0d", count, overflow);

    // Reset during the second cycle of a RISING run discards the partial run.
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    check_val("rst_run_nocount", int'(count), 0);
    step(1'b1, 1'b1, 1'b0);
    check_val("rst_run_count", int'(count), 1);
    $display("scenario mid_reset: count=%0d", count);

    // Randomized runs of f_in with random en/clr.
    for (int r = 0; r < 120; r++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++)
        step(lvl, ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3));
    end
    $display("scenario random: count=%0d thresh_hit=%0d overflow=%0d", count, thresh_hit, overflow);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
